irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt aggregation stage downstream of the peripheral block: it collects up to N_SRC interrupt request lines (the peripheral `irq_o` plus future sources) and produces a single masked, prioritised interrupt to the CPU. It provides a per-source pending register, a mask register and a level/edge mode register. It also has a cause register holding the highest-priority pending index. The CPU accesses these registers over the same word-addressed peripheral bus signalling (`addr_i`, `data_i`, `data_o`, `sel_i`, `wr_i`).

## Interface
- N_SRC, 8: number of interrupt sources; 1..31.
- DATA_WIDTH, 32: bus data width; must be at least N_SRC+1.
- clk_i  in  1  single system clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- addr_i  in  DATA_WIDTH  byte address; only `addr_i[3:2]` is decoded, all other bits are ignored.
- data_i  in  DATA_WIDTH  write data.
- data_o  out  DATA_WIDTH  registered read data.
- sel_i  in  1  block select; an access occurs on any cycle with `sel_i`=1.
- wr_i  in  1  1 = write, 0 = read; qualified by `sel_i`.
- irq_src_i  in  N_SRC  synchronous interrupt request lines; bit 0 is the peripheral `irq_o`.
- irq_o  out  1  registered interrupt request to the CPU.

## Operation
- Register map, selected by `addr_i[3:2]`:
  - 0 PENDING: read returns pending bits; a write of 1 to a bit clears that pending bit (W1C).
  - 1 MASK: read/write; 1 = source enabled.
  - 2 EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - 3 CAUSE: read-only. Bit 31 (DATA_WIDTH-1) is the valid flag; bits [4:0] hold the index of the lowest-numbered source that is both pending and unmasked. Writes to CAUSE are ignored.
- Unused upper bits read as 0. Register bits at positions N_SRC and above read as 0 and ignore writes.
- Input stage: `src_q <= irq_src_i` and `src_qq <= src_q` every cycle. The rise condition is `src_q & ~src_qq`.
- Pending update in level mode: `pending[i] <= src_q[i]`. W1C has no effect on level-mode bits.
- Pending update in edge mode: `pending[i]` is set on a rise and cleared by a W1C of bit i.
  - If a rise and a W1C hit the same bit in the same cycle, set wins and the bit stays 1.
- Switching a bit from edge mode to level mode: on the next edge the bit takes the value of `src_q[i]`.
- Switching a bit from level mode to edge mode: the bit keeps its current value until cleared.
- Active vector: `active = pending & mask`.
  - `irq_o <= |active`.
  - CAUSE valid = `|active`; CAUSE index = priority encode of `active`, with the lowest index winning.
  - When valid is 0, the index field is 0.
- Masking a source does not clear its pending bit. Unmasking a bit that is already pending re-asserts `irq_o`.
- Reset (`rst_i`=0, asynchronous, including in the middle of an access):
  - `src_q`, `src_qq`, pending, MASK, EDGE, `irq_o` and `data_o` all go to 0.
  - No spurious rise is detected on the first cycle after reset release, because `src_qq` was 0 and the source must actually be sampled.

## Timing
- Write: `sel_i`=1 and `wr_i`=1 at edge k. The register updates at edge k. The effect appears on `irq_o` after edge k+1.
- Read: `sel_i`=1 and `wr_i`=0 at edge k. `data_o` is valid after edge k and holds until the next read. Zero wait states; no back-pressure.
- Read data reflects register state before edge k, i.e. the read-before-write value.
- Source latency: a source first sampled high at edge k gives `src_q`=1 after edge k, pending=1 after edge k+1, `irq_o`=1 after edge k+2.
- W1C clear latency: a W1C at edge k (edge mode, no new rise) gives pending=0 after edge k, `irq_o`=0 after edge k+1.
- Back-to-back accesses are allowed on consecutive cycles. A read in the cycle after a write returns the written value.

## Test plan
- Reset values: hold `rst_i`=0 mid-stream with MASK=0xFF, then release. Required: `irq_o`=0, `data_o`=0, and all four registers read 0x0.
- Level source: EDGE=0, MASK=0x01; raise `irq_src_i[0]` before edge k. Required:
  - `irq_o`=1 after edge k+2; CAUSE reads 0x8000_0000.
  - Dropping the source gives `irq_o`=0 two cycles later.
- Edge latch, W1C and collision:
  - EDGE=0x04, MASK=0x04; send a 1-cycle pulse on bit 2. Required: PENDING=0x04, CAUSE=0x8000_0002, `irq_o` held high.
  - Write PENDING=0x04. Required: PENDING=0x00 and `irq_o`=0 one cycle later.
  - Issue a W1C in the same cycle as a new rise. Required: PENDING stays 0x04.
- Priority and mask:
  - Sources 5 and 3 pending, MASK=0xFF. Required: CAUSE=0x8000_0003.
  - Then MASK=0xF7. Required: CAUSE=0x8000_0005.
  - Then MASK=0x00. Required: CAUSE=0x0000_0000, `irq_o`=0, PENDING still 0x28.
- Bus access: write MASK=0xFFFF_FFFF with N_SRC=8. Required: MASK reads 0x0000_00FF. A write to CAUSE leaves CAUSE unchanged. `addr_i`=0x1004 aliases MASK.
- Async reset mid-operation: assert `rst_i` low between clock edges while `irq_o`=1. Required: `irq_o` and pending go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - masked, prioritised interrupt aggregator with pending/mask/edge/cause registers
module irq_controller #(
    parameter int N_SRC      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  sel_i,
    input  logic                  wr_i,
    input  logic [N_SRC-1:0]      irq_src_i,
    output logic                  irq_o
);

    localparam int PAD = DATA_WIDTH - N_SRC;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CAUSE   = 2'd3;

    logic [N_SRC-1:0]      src_q;
    logic [N_SRC-1:0]      src_qq;
    logic [N_SRC-1:0]      pending;
    logic [N_SRC-1:0]      pending_next;
    logic [N_SRC-1:0]      mask_q;
    logic [N_SRC-1:0]      edge_mode;
    logic [N_SRC-1:0]      rise;
    logic [N_SRC-1:0]      w1c;
    logic [N_SRC-1:0]      active;
    logic [1:0]            reg_sel;
    logic                  wr_en;
    logic                  cause_valid;
    logic [4:0]            cause_idx;
    logic [DATA_WIDTH-1:0] cause_word;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  bus_unused;

    // Only addr_i[3:2] decodes; bits above the source count are dropped on write.
    assign bus_unused = ^{addr_i[DATA_WIDTH-1:4], addr_i[1:0], data_i[DATA_WIDTH-1:N_SRC]};

    assign reg_sel = addr_i[3:2];
    assign wr_en   = sel_i & wr_i;
    assign rise    = src_q & ~src_qq;
    assign w1c     = (wr_en && reg_sel == REG_PENDING) ? data_i[N_SRC-1:0] : '0;
    assign active  = pending & mask_q;

    // Two-flop input stage; src_qq starting at 0 means a rise needs a real sample after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_q  <= '0;
            src_qq <= '0;
        end else begin
            src_q  <= irq_src_i;
            src_qq <= src_q;
        end
    end

    // Per-bit pending: level bits follow src_q, edge bits latch rises and clear on W1C (rise wins).
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (edge_mode[i]) begin
                pending_next[i] = rise[i] | (pending[i] & ~w1c[i]);
            end else begin
                pending_next[i] = src_q[i];
            end
        end
    end

    // Pending register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // MASK and EDGE writable registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mask_q    <= '0;
            edge_mode <= '0;
        end else if (wr_en) begin
            if (reg_sel == REG_MASK) begin
                mask_q <= data_i[N_SRC-1:0];
            end
            if (reg_sel == REG_EDGE) begin
                edge_mode <= data_i[N_SRC-1:0];
            end
        end
    end

    // Lowest-numbered active source wins; index stays 0 when nothing is active.
    always_comb begin
        cause_valid = |active;
        cause_idx   = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause_idx = 5'(i);
            end
        end
    end

    // Cause word layout: valid flag in the top bit, index in the low five bits.
    always_comb begin
        cause_word                 = '0;
        cause_word[DATA_WIDTH-1]   = cause_valid;
        cause_word[4:0]            = cause_idx;
    end

    // Read mux over pre-edge register state.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata = {{PAD{1'b0}}, pending};
            REG_MASK:    rdata = {{PAD{1'b0}}, mask_q};
            REG_EDGE:    rdata = {{PAD{1'b0}}, edge_mode};
            REG_CAUSE:   rdata = cause_word;
            default:     rdata = '0;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (sel_i && !wr_i) begin
            data_o <= rdata;
        end
    end

    // Registered CPU interrupt.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |active;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed table-driven bench for irq_controller
module tb_irq_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        wr;
    logic [7:0]  src;
    logic        irq;

    int tests;
    int fails;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  src;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.N_SRC(8), .DATA_WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (rdata),
        .sel_i     (sel),
        .wr_i      (wr),
        .irq_src_i (src),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        tick();
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic add(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] sr, input logic c, input logic [31:0] ed, input logic ei);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.wdata = d; v.src = sr;
        v.chk_d = c; v.exp_d = ed; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    logic [31:0] rd;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; src = '0;

        // Reset values, with reset asserted in the middle of an access.
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_write(32'h4, 32'hFF);
        sel = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_data", rdata, 32'h0);
        tick();
        sel = 1'b0; wr = 1'b0;
        rst_n = 1'b1;
        tick();
        bus_read(32'h0, rd); check("rst_pending", rd, 32'h0);
        bus_read(32'h4, rd); check("rst_mask", rd, 32'h0);
        bus_read(32'h8, rd); check("rst_edge", rd, 32'h0);
        bus_read(32'hC, rd); check("rst_cause", rd, 32'h0);
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        // Edge latch on a one-cycle pulse.
        bus_write(32'h8, 32'h04);
        bus_write(32'h4, 32'h04);
        src = 8'h04; tick();
        src = 8'h00; tick(); tick(); tick();
        check("edge_irq_held", {31'b0, irq}, 32'h1);
        bus_read(32'h0, rd); check("edge_pending", rd, 32'h04);
        bus_read(32'hC, rd); check("edge_cause", rd, 32'h8000_0002);
        check("edge_irq_held2", {31'b0, irq}, 32'h1);

        // W1C clears the bit, irq drops one cycle later.
        bus_write(32'h0, 32'h04);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        bus_read(32'h0, rd); check("w1c_pending", rd, 32'h00);
        check("w1c_irq_low", {31'b0, irq}, 32'h0);

        // W1C colliding with a new rise: set wins.
        src = 8'h04; tick();
        src = 8'h00; tick(); tick();
        src = 8'h04; tick();
        src = 8'h00;
        bus_write(32'h0, 32'h04);
        bus_read(32'h0, rd); check("collide_pending", rd, 32'h04);
        tick();
        check("collide_irq", {31'b0, irq}, 32'h1);

        // Async reset between edges while irq is high.
        bus_read(32'h0, rd); check("pre_arst_data", rd, 32'h04);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'h0);
        check("arst_data", rdata, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        bus_read(32'h0, rd); check("arst_pending", rd, 32'h0);
        bus_read(32'h4, rd); check("arst_mask", rd, 32'h0);

        // Table: level source, priority/mask, bus decode.
        //   sel   wr    addr          wdata          src    chk   exp_d          irq
        add(1'b1, 1'b1, 32'h8,        32'h0,         8'h00, 1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b1, 32'h4,        32'h01,        8'h00, 1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h01, 1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h01, 1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b0, 32'hC,        32'h0,         8'h01, 1'b1, 32'h8000_0000, 1'b1);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h00, 1'b0, 32'h0,         1'b1);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h00, 1'b0, 32'h0,         1'b1);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h00, 1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b1, 32'h4,        32'hFF,        8'h28, 1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,        32'h0,         8'h28, 1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b0, 32'hC,        32'h0,         8'h28, 1'b1, 32'h8000_0003, 1'b1);
        add(1'b1, 1'b1, 32'h4,        32'hF7,        8'h28, 1'b0, 32'h0,         1'b1);
        add(1'b1, 1'b0, 32'hC,        32'h0,         8'h28, 1'b1, 32'h8000_0005, 1'b1);
        add(1'b1, 1'b1, 32'hC,        32'hFFFF_FFFF, 8'h28, 1'b0, 32'h0,         1'b1);
        add(1'b1, 1'b0, 32'hC,        32'h0,         8'h28, 1'b1, 32'h8000_0005, 1'b1);
        add(1'b1, 1'b1, 32'h4,        32'h00,        8'h28, 1'b0, 32'h0,         1'b1);
        add(1'b1, 1'b0, 32'hC,        32'h0,         8'h28, 1'b1, 32'h0,         1'b0);
        add(1'b1, 1'b0, 32'h0,        32'h0,         8'h28, 1'b1, 32'h28,        1'b0);
        add(1'b1, 1'b0, 32'h4,        32'h0,         8'h00, 1'b1, 32'h0,         1'b0);
        add(1'b1, 1'b1, 32'h4,        32'hFFFF_FFFF, 8'h00, 1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b0, 32'h4,        32'h0,         8'h00, 1'b1, 32'hFF,        1'b0);
        add(1'b1, 1'b0, 32'h1004,     32'h0,         8'h00, 1'b1, 32'hFF,        1'b0);
        add(1'b1, 1'b0, 32'h8,        32'h0,         8'h00, 1'b1, 32'h0,         1'b0);
        add(1'b1, 1'b0, 32'h0,        32'h0,         8'h00, 1'b1, 32'h0,         1'b0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel; wr = vecs[i].wr; addr = vecs[i].addr;
            wdata = vecs[i].wdata; src = vecs[i].src;
            tick();
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
            if (vecs[i].chk_d) begin
                check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_d);
            end
        end
        sel = 1'b0; wr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
